// File: rtl/bist_sig_checker.sv
// -----------------------------------------------------------------------------
// bist_sig_checker
//
// BIST session controller and signature comparator for a serial-input
// signature register (sir). It clears the sir for one cycle. It then enables
// the sir and the upstream pattern source for exactly TEST_LEN clocks. It waits
// one settle cycle and samples the finished signature. Finally it compares the
// signature with GOLDEN and reports done/pass.
//
// Ports:
//   i_clk      : single clock, all state changes on posedge
//   i_reset    : asynchronous active-high reset, clears all state
//   i_start    : begin a session (honoured only in IDLE or DONE)
//   i_abort    : cancel a running session (honoured in CLEAR, RUN, SETTLE)
//   i_sig_in   : sir q output, sampled only in SETTLE
//   o_sir_clr  : sir reset, high for the single CLEAR cycle
//   o_sir_en   : sir enable, high for the TEST_LEN RUN cycles
//   o_tpg_en   : pattern source enable, same timing as o_sir_en
//   o_busy     : session in progress (CLEAR, RUN, SETTLE)
//   o_done     : result valid
//   o_pass     : captured signature equals GOLDEN (meaningful while o_done=1)
//   o_sig_out  : captured signature
//   o_cycles   : current or final RUN cycle count
// -----------------------------------------------------------------------------
module bist_sig_checker #(
  parameter int                   SIG_WIDTH = 4,
  parameter int                   TEST_LEN  = 15,
  parameter int                   CNT_WIDTH = 8,
  parameter logic [SIG_WIDTH-1:0] GOLDEN    = 4'hA
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [SIG_WIDTH-1:0] i_sig_in,
  output logic                 o_sir_clr,
  output logic                 o_sir_en,
  output logic                 o_tpg_en,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [SIG_WIDTH-1:0] o_sig_out,
  output logic [CNT_WIDTH-1:0] o_cycles
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // Count value seen on the last RUN edge, and the value left behind after it.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TEST_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FINAL = CNT_WIDTH'(TEST_LEN);

  logic [2:0]           r_state;
  logic [CNT_WIDTH-1:0] r_count;
  logic [SIG_WIDTH-1:0] r_sig;
  logic                 r_pass;
  logic                 r_done;

  logic w_in_clear;
  logic w_in_run;
  logic w_in_settle;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_sig   <= '0;
      r_pass  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_CLEAR;
            r_count <= '0;
          end
        end

        S_CLEAR: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_pass  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          // On abort, the count is left untouched so o_cycles shows how far
          // the session got.
          if (i_abort) begin
            r_state <= S_IDLE;
            r_pass  <= 1'b0;
            r_done  <= 1'b0;
          end else if (r_count == CNT_LAST) begin
            r_count <= CNT_FINAL;
            r_state <= S_SETTLE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        S_SETTLE: begin
          // Abort takes priority over publishing the result.
          if (i_abort) begin
            r_state <= S_IDLE;
            r_pass  <= 1'b0;
            r_done  <= 1'b0;
          end else begin
            r_sig   <= i_sig_in;
            r_pass  <= (i_sig_in == GOLDEN);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          // Back-to-back session: go straight to CLEAR without visiting IDLE.
          if (i_start) begin
            r_state <= S_CLEAR;
            r_count <= '0;
            r_pass  <= 1'b0;
            r_done  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_pass  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // All control outputs decode from the state register only, so start/abort
  // never reach an output combinationally.
  assign w_in_clear  = (r_state == S_CLEAR);
  assign w_in_run    = (r_state == S_RUN);
  assign w_in_settle = (r_state == S_SETTLE);

  assign o_sir_clr = w_in_clear;
  assign o_sir_en  = w_in_run;
  assign o_tpg_en  = w_in_run;
  assign o_busy    = w_in_clear | w_in_run | w_in_settle;
  assign o_done    = r_done;
  assign o_pass    = r_pass;
  assign o_sig_out = r_sig;
  assign o_cycles  = r_count;

endmodule

// File: tb/tb_bist_sig_checker.sv
// -----------------------------------------------------------------------------
// tb_bist_sig_checker
//
// Two checker instances share start/abort/reset:
//   u_dut3 : TEST_LEN=3, pattern 1,0,1   -> signature 4'hA (pass)
//   u_dut4 : TEST_LEN=4, pattern 1,0,1,1 -> signature 4'hD (fail)
// Each instance drives its own sir and pattern source. The sir is a 4-bit
// shift register that loads y at the MSB and shifts right. Expected results
// are queued when a session is started and popped when done rises.
// -----------------------------------------------------------------------------
module tb_bist_sig_checker;

  logic clk;
  logic reset;
  logic start;
  logic abort;

  logic [3:0] sig3, sigout3;
  logic       clr3, en3, tpg3, busy3, done3, pass3;
  logic [7:0] cyc3;
  logic [3:0] sig4, sigout4;
  logic       clr4, en4, tpg4, busy4, done4, pass4;
  logic [7:0] cyc4;

  // Pattern bits are consumed from bit 0 upward.
  logic [7:0] pat3 = 8'b0000_0101;
  logic [7:0] pat4 = 8'b0000_1101;
  logic [2:0] idx3, idx4;
  logic       y3, y4;

  typedef struct {
    logic [3:0] sig;
    logic       pass;
    logic [7:0] cyc;
    int         lat;
  } exp_t;

  exp_t sb3[$];
  exp_t sb4[$];

  int errors = 0;
  int checks = 0;

  bist_sig_checker #(.SIG_WIDTH(4), .TEST_LEN(3), .CNT_WIDTH(8), .GOLDEN(4'hA)) u_dut3 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort), .i_sig_in(sig3),
    .o_sir_clr(clr3), .o_sir_en(en3), .o_tpg_en(tpg3), .o_busy(busy3),
    .o_done(done3), .o_pass(pass3), .o_sig_out(sigout3), .o_cycles(cyc3)
  );

  bist_sig_checker #(.SIG_WIDTH(4), .TEST_LEN(4), .CNT_WIDTH(8), .GOLDEN(4'hA)) u_dut4 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort), .i_sig_in(sig4),
    .o_sir_clr(clr4), .o_sir_en(en4), .o_tpg_en(tpg4), .o_busy(busy4),
    .o_done(done4), .o_pass(pass4), .o_sig_out(sigout4), .o_cycles(cyc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign y3 = tpg3 & pat3[idx3];
  assign y4 = tpg4 & pat4[idx4];

  // Pattern sources: restart on sir_clr, advance while enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      idx3 <= '0;
    else if (clr3)  idx3 <= '0;
    else if (tpg3)  idx3 <= idx3 + 3'd1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      idx4 <= '0;
    else if (clr4)  idx4 <= '0;
    else if (tpg4)  idx4 <= idx4 + 3'd1;
  end

  // sir models: synchronous clear, shift right with y entering at the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sig3 <= '0;
    else if (clr3)  sig3 <= '0;
    else if (en3)   sig3 <= {y3, sig3[3:1]};
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      sig4 <= '0;
    else if (clr4)  sig4 <= '0;
    else if (en4)   sig4 <= {y4, sig4[3:1]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete session on both instances. When poke is set, start is
  // pulsed during RUN; it must not change the timing.
  task automatic do_session(input bit poke, input string name);
    int   n;
    int   d3_at;
    int   d4_at;
    int   en3_cnt;
    int   en4_cnt;
    int   clr_cnt;
    exp_t e;
    sb3.push_back('{sig: 4'hA, pass: 1'b1, cyc: 8'd3, lat: 5});
    sb4.push_back('{sig: 4'hD, pass: 1'b0, cyc: 8'd4, lat: 6});
    start = 1'b1;
    tick();
    start = 1'b0;
    check({name, "_clr3"},  32'(clr3),  32'd1);
    check({name, "_busy3"}, 32'(busy3), 32'd1);
    check({name, "_en3"},   32'(en3),   32'd0);
    check({name, "_done3"}, 32'(done3), 32'd0);
    check({name, "_pass3"}, 32'(pass3), 32'd0);
    check({name, "_done4"}, 32'(done4), 32'd0);
    n = 0; d3_at = 0; d4_at = 0; en3_cnt = 0; en4_cnt = 0; clr_cnt = 0;
    while ((d3_at == 0 || d4_at == 0) && n < 40) begin
      start = (poke && n == 2) ? 1'b1 : 1'b0;
      tick();
      n++;
      if (en3)  en3_cnt++;
      if (en4)  en4_cnt++;
      if (clr3) clr_cnt++;
      if (done3 && d3_at == 0) begin
        d3_at = n;
        check({name, "_sb3_nonempty"}, 32'(sb3.size() != 0), 32'd1);
        if (sb3.size() != 0) begin
          e = sb3.pop_front();
          check({name, "_sig3"},  32'(sigout3), 32'(e.sig));
          check({name, "_pass3"}, 32'(pass3),   32'(e.pass));
          check({name, "_cyc3"},  32'(cyc3),    32'(e.cyc));
          check({name, "_lat3"},  32'(n),       32'(e.lat));
        end
      end
      if (done4 && d4_at == 0) begin
        d4_at = n;
        check({name, "_sb4_nonempty"}, 32'(sb4.size() != 0), 32'd1);
        if (sb4.size() != 0) begin
          e = sb4.pop_front();
          check({name, "_sig4"},  32'(sigout4), 32'(e.sig));
          check({name, "_pass4"}, 32'(pass4),   32'(e.pass));
          check({name, "_cyc4"},  32'(cyc4),    32'(e.cyc));
          check({name, "_lat4"},  32'(n),       32'(e.lat));
        end
      end
    end
    start = 1'b0;
    check({name, "_done3_seen"}, 32'(d3_at != 0), 32'd1);
    check({name, "_done4_seen"}, 32'(d4_at != 0), 32'd1);
    check({name, "_en3_cycles"}, 32'(en3_cnt), 32'd3);
    check({name, "_en4_cycles"}, 32'(en4_cnt), 32'd4);
    check({name, "_clr_once"},   32'(clr_cnt), 32'd0);
    check({name, "_busy4_end"},  32'(busy4),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();

    // Reset state.
    check("rst_busy3",   32'(busy3),   32'd0);
    check("rst_done3",   32'(done3),   32'd0);
    check("rst_pass3",   32'(pass3),   32'd0);
    check("rst_clr3",    32'(clr3),    32'd0);
    check("rst_en3",     32'(en3),     32'd0);
    check("rst_tpg3",    32'(tpg3),    32'd0);
    check("rst_sigout3", 32'(sigout3), 32'd0);
    check("rst_cyc3",    32'(cyc3),    32'd0);
    reset = 1'b0;
    tick();

    // Abort in IDLE is ignored.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_busy3", 32'(busy3), 32'd0);

    // Pass (TEST_LEN=3) and fail (TEST_LEN=4) sessions.
    do_session(1'b0, "s1");
    check("s1_done_hold3", 32'(done3), 32'd1);
    check("s1_pass_hold3", 32'(pass3), 32'd1);

    // Abort in DONE is ignored.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("done_abort_done3", 32'(done3), 32'd1);
    check("done_abort_pass3", 32'(pass3), 32'd1);

    // Restart from DONE, with a start pulse during RUN.
    do_session(1'b1, "s2");

    // Abort on the second RUN cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ab_clr3", 32'(clr3), 32'd1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy3", 32'(busy3), 32'd0);
    check("ab_en3",   32'(en3),   32'd0);
    check("ab_done3", 32'(done3), 32'd0);
    check("ab_pass3", 32'(pass3), 32'd0);
    check("ab_cyc3",  32'(cyc3),  32'd1);
    check("ab_cyc4",  32'(cyc4),  32'd1);
    tick();
    check("ab_idle_busy3", 32'(busy3), 32'd0);

    // Clean session after abort.
    do_session(1'b0, "s3");

    // start+abort together in the first RUN cycle: abort wins.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_run_busy3", 32'(busy3), 32'd0);
    check("sa_run_done3", 32'(done3), 32'd0);
    check("sa_run_cyc3",  32'(cyc3),  32'd0);

    // start+abort together in IDLE: start wins.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_idle_clr3",  32'(clr3),  32'd1);
    check("sa_idle_busy3", 32'(busy3), 32'd1);
    tick();
    tick();
    check("mid_cyc3_pre", 32'(cyc3), 32'd1);

    // Asynchronous reset mid-RUN, between edges.
    #2;
    reset = 1'b1;
    #1;
    check("arst_en3",     32'(en3),     32'd0);
    check("arst_tpg3",    32'(tpg3),    32'd0);
    check("arst_busy3",   32'(busy3),   32'd0);
    check("arst_done3",   32'(done3),   32'd0);
    check("arst_cyc3",    32'(cyc3),    32'd0);
    check("arst_sigout3", 32'(sigout3), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Recovery after reset.
    do_session(1'b0, "s4");

    check("sb3_drained", 32'(sb3.size()), 32'd0);
    check("sb4_drained", 32'(sb4.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
